// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared ship classes, board size and scoring FSM states
package battleship_pkg;

  localparam int BOARD_DIM   = 10;
  localparam int NUM_CLASSES = 5;

  typedef enum logic [2:0] {
    PATROL     = 3'd0,
    SUBMARINE  = 3'd1,
    DESTROYER  = 3'd2,
    BATTLESHIP = 3'd3,
    CARRIER    = 3'd4
  } ship_class_e;

  localparam logic [2:0] SHIP_CELLS [NUM_CLASSES] = '{3'd4, 3'd3, 3'd3, 3'd4, 3'd5};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCORE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // The checker may flag several classes; the lowest one is credited.
  function automatic ship_class_e lowest_set(input logic [NUM_CLASSES-1:0] v);
    ship_class_e r;
    r = PATROL;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (v[i]) r = ship_class_e'(3'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/key_press_sync.sv
// rtl/key_press_sync.sv - two-flop synchronizer and falling-edge press pulse for an active-low key
module key_press_sync (
  input  logic clock,
  input  logic reset_L,
  input  logic key_L,
  output logic key_sync_L,
  output logic press
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= key_L;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign key_sync_L = sync_q;
  assign press      = prev_q & ~sync_q;

endmodule

// File: rtl/shot_score_keeper.sv
// rtl/shot_score_keeper.sv - scores one shot per key press and keeps game state; SHOT_LIMIT_EN adds a shot budget
module shot_score_keeper
  import battleship_pkg::*;
#(
  parameter int BIG_BOMBS   = 2,
  parameter int TOTAL_CELLS = 19
`ifdef SHOT_LIMIT_EN
  , parameter int MAX_SHOTS = 30
`endif
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       score_L,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       big,
  input  logic       something_wrong,
  input  logic       is_hit,
  input  logic       is_near_miss,
  input  logic       is_miss,
  input  logic [4:0] biggest_ship,
  output logic       shot_done,
  output logic       reject,
  output logic       repeat_shot,
  output logic       hit_led,
  output logic       near_led,
  output logic       miss_led,
  output logic [4:0] ship_hit,
  output logic [4:0] ship_sunk,
  output logic [4:0] num_hits,
  output logic [3:0] hits_ones,
  output logic [3:0] hits_tens,
  output logic [1:0] big_left,
  output logic       game_over
`ifdef SHOT_LIMIT_EN
  , output logic [4:0] shots_left
`endif
);

  logic key_sync_L, press;

  key_press_sync u_sync (
    .clock     (clock),
    .reset_L   (reset_L),
    .key_L     (score_L),
    .key_sync_L(key_sync_L),
    .press     (press)
  );

  state_e     state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic       big_q, big_d, wrong_q, wrong_d;
  logic       hit_q, hit_d, near_q, near_d, miss_q, miss_d;
  logic [4:0] ship_q, ship_d;
  logic       shot_done_q, shot_done_d, reject_q, reject_d, repeat_q, repeat_d;
  logic       hit_led_q, hit_led_d, near_led_q, near_led_d, miss_led_q, miss_led_d;
  logic [4:0] ship_hit_q, ship_hit_d, num_hits_q, num_hits_d;
  logic [1:0] big_left_q, big_left_d;
  logic       game_over_q, game_over_d;
  logic [BOARD_DIM*BOARD_DIM-1:0] fired_q, fired_d;
  logic [2:0] cnt_q [NUM_CLASSES];
  logic [2:0] cnt_d [NUM_CLASSES];
`ifdef SHOT_LIMIT_EN
  logic [4:0] shots_left_q, shots_left_d;
`endif

  logic        in_range;
  logic [6:0]  cell_idx;
  ship_class_e cls;

  assign in_range = (x_q >= 4'd1) && (x_q <= 4'(BOARD_DIM)) &&
                    (y_q >= 4'd1) && (y_q <= 4'(BOARD_DIM));
  assign cell_idx = ({3'b0, y_q} - 7'd1) * 7'(BOARD_DIM) + {3'b0, x_q} - 7'd1;
  assign cls      = lowest_set(ship_q);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    big_d        = big_q;
    wrong_d      = wrong_q;
    hit_d        = hit_q;
    near_d       = near_q;
    miss_d       = miss_q;
    ship_d       = ship_q;
    shot_done_d  = 1'b0;
    reject_d     = reject_q;
    repeat_d     = repeat_q;
    hit_led_d    = hit_led_q;
    near_led_d   = near_led_q;
    miss_led_d   = miss_led_q;
    ship_hit_d   = ship_hit_q;
    num_hits_d   = num_hits_q;
    big_left_d   = big_left_q;
    fired_d      = fired_q;
    cnt_d        = cnt_q;
    game_over_d  = game_over_q | (num_hits_q == 5'(TOTAL_CELLS));
`ifdef SHOT_LIMIT_EN
    shots_left_d = shots_left_q;
    game_over_d  = game_over_d | (shots_left_q == 5'd0);
`endif
    case (state_q)
      IDLE: begin
        if (press) begin
          x_d      = x;
          y_d      = y;
          big_d    = big;
          wrong_d  = something_wrong;
          hit_d    = is_hit;
          near_d   = is_near_miss;
          miss_d   = is_miss;
          ship_d   = biggest_ship;
          reject_d = 1'b0;
          repeat_d = 1'b0;
          state_d  = SCORE;
        end
      end
      SCORE: begin
        shot_done_d = 1'b1;
        state_d     = RELEASE;
        if (game_over_q || wrong_q || !in_range || (big_q && big_left_q == 2'd0)) begin
          reject_d = 1'b1;
        end else begin
          hit_led_d  = hit_q;
          near_led_d = near_q;
          miss_led_d = miss_q;
          ship_hit_d = ship_q;
          if (big_q) big_left_d = big_left_q - 2'd1;
`ifdef SHOT_LIMIT_EN
          if (shots_left_q != 5'd0) shots_left_d = shots_left_q - 5'd1;
`endif
          if (fired_q[cell_idx]) begin
            repeat_d = 1'b1;
          end else begin
            fired_d[cell_idx] = 1'b1;
            if (hit_q) begin
              if (num_hits_q < 5'(TOTAL_CELLS)) num_hits_d = num_hits_q + 5'd1;
              if (|ship_q && cnt_q[cls] < SHIP_CELLS[cls]) cnt_d[cls] = cnt_q[cls] + 3'd1;
            end
          end
        end
      end
      RELEASE: begin
        if (key_sync_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      big_q        <= 1'b0;
      wrong_q      <= 1'b0;
      hit_q        <= 1'b0;
      near_q       <= 1'b0;
      miss_q       <= 1'b0;
      ship_q       <= '0;
      shot_done_q  <= 1'b0;
      reject_q     <= 1'b0;
      repeat_q     <= 1'b0;
      hit_led_q    <= 1'b0;
      near_led_q   <= 1'b0;
      miss_led_q   <= 1'b0;
      ship_hit_q   <= '0;
      num_hits_q   <= '0;
      big_left_q   <= 2'(BIG_BOMBS);
      game_over_q  <= 1'b0;
      fired_q      <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= '0;
`ifdef SHOT_LIMIT_EN
      shots_left_q <= 5'(MAX_SHOTS);
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      big_q        <= big_d;
      wrong_q      <= wrong_d;
      hit_q        <= hit_d;
      near_q       <= near_d;
      miss_q       <= miss_d;
      ship_q       <= ship_d;
      shot_done_q  <= shot_done_d;
      reject_q     <= reject_d;
      repeat_q     <= repeat_d;
      hit_led_q    <= hit_led_d;
      near_led_q   <= near_led_d;
      miss_led_q   <= miss_led_d;
      ship_hit_q   <= ship_hit_d;
      num_hits_q   <= num_hits_d;
      big_left_q   <= big_left_d;
      game_over_q  <= game_over_d;
      fired_q      <= fired_d;
      cnt_q        <= cnt_d;
`ifdef SHOT_LIMIT_EN
      shots_left_q <= shots_left_d;
`endif
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_sunk
    assign ship_sunk[k] = (cnt_q[k] == SHIP_CELLS[k]);
  end

  assign shot_done   = shot_done_q;
  assign reject      = reject_q;
  assign repeat_shot = repeat_q;
  assign hit_led     = hit_led_q;
  assign near_led    = near_led_q;
  assign miss_led    = miss_led_q;
  assign ship_hit    = ship_hit_q;
  assign num_hits    = num_hits_q;
  assign hits_tens   = (num_hits_q >= 5'd10) ? 4'd1 : 4'd0;
  assign hits_ones   = (num_hits_q >= 5'd10) ? 4'(num_hits_q - 5'd10) : 4'(num_hits_q);
  assign big_left    = big_left_q;
  assign game_over   = game_over_q;
`ifdef SHOT_LIMIT_EN
  assign shots_left  = shots_left_q;
`endif

endmodule

// File: tb/tb_shot_score_keeper.sv
// tb/tb_shot_score_keeper.sv - randomized self-checking bench for shot_score_keeper against a board-level model
module tb_shot_score_keeper;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       score_L = 1'b1;
  logic [3:0] x = '0, y = '0;
  logic       big = 1'b0, something_wrong = 1'b0;
  logic       is_hit = 1'b0, is_near_miss = 1'b0, is_miss = 1'b0;
  logic [4:0] biggest_ship = '0;
  logic       shot_done, reject, repeat_shot, hit_led, near_led, miss_led, game_over;
  logic [4:0] ship_hit, ship_sunk, num_hits;
  logic [3:0] hits_ones, hits_tens;
  logic [1:0] big_left;
`ifdef SHOT_LIMIT_EN
  logic [4:0] shots_left;
`endif

  shot_score_keeper dut (
    .clock(clock), .reset_L(reset_L), .score_L(score_L), .x(x), .y(y), .big(big),
    .something_wrong(something_wrong), .is_hit(is_hit), .is_near_miss(is_near_miss),
    .is_miss(is_miss), .biggest_ship(biggest_ship), .shot_done(shot_done), .reject(reject),
    .repeat_shot(repeat_shot), .hit_led(hit_led), .near_led(near_led), .miss_led(miss_led),
    .ship_hit(ship_hit), .ship_sunk(ship_sunk), .num_hits(num_hits), .hits_ones(hits_ones),
    .hits_tens(hits_tens), .big_left(big_left), .game_over(game_over)
`ifdef SHOT_LIMIT_EN
    , .shots_left(shots_left)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Board: class 0 (4 cells), 1 (3), 2 (3), 3 (4), 4 (5).
  int cell_x [19] = '{7, 8, 9, 10, 1, 1, 1, 3, 4, 5, 2, 3, 4, 5, 10, 10, 10, 10, 10};
  int cell_y [19] = '{6, 6, 1, 1,  1, 2, 3, 3, 3, 3, 8, 8, 8, 8, 4,  5,  6,  7,  8};
  int need   [5]  = '{4, 3, 3, 4, 5};

  function automatic int ship_at(input int px, input int py);
    for (int i = 0; i < 19; i++) begin
      if (cell_x[i] == px && cell_y[i] == py)
        return (i < 4) ? 0 : (i < 7) ? 1 : (i < 10) ? 2 : (i < 14) ? 3 : 4;
    end
    return -1;
  endfunction

  bit fired_m [16][16];
  int hits_m, bl_m, go_m, rej_m, rpt_m, hl_m, nl_m, ml_m, sh_m, sl_m;
  int cnt_m [5];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) fired_m[i][j] = 1'b0;
    for (int k = 0; k < 5; k++) cnt_m[k] = 0;
    hits_m = 0; bl_m = 2; go_m = 0; rej_m = 0; rpt_m = 0;
    hl_m = 0; nl_m = 0; ml_m = 0; sh_m = 0; sl_m = 30;
  endtask

  task automatic check_outputs(input string ctx);
    int sunk;
    sunk = 0;
    for (int k = 0; k < 5; k++) if (cnt_m[k] == need[k]) sunk |= (1 << k);
    check({ctx, " reject"}, reject, rej_m);
    check({ctx, " repeat_shot"}, repeat_shot, rpt_m);
    check({ctx, " hit_led"}, hit_led, hl_m);
    check({ctx, " near_led"}, near_led, nl_m);
    check({ctx, " miss_led"}, miss_led, ml_m);
    check({ctx, " ship_hit"}, ship_hit, sh_m);
    check({ctx, " ship_sunk"}, ship_sunk, sunk);
    check({ctx, " num_hits"}, num_hits, hits_m);
    check({ctx, " hits_tens"}, hits_tens, hits_m / 10);
    check({ctx, " hits_ones"}, hits_ones, hits_m % 10);
    check({ctx, " big_left"}, big_left, bl_m);
    check({ctx, " game_over"}, game_over, go_m);
`ifdef SHOT_LIMIT_EN
    check({ctx, " shots_left"}, shots_left, sl_m);
`endif
  endtask

  task automatic press(input int px, input int py, input int pbig, input int pwrong, input int phold);
    int cls, hit, near, miss, bs, pulses;
    cls  = ship_at(px, py);
    hit  = (cls >= 0);
    near = hit ? 0 : int'($urandom_range(0, 1));
    miss = (!hit && !near);
    bs   = hit ? ((1 << cls) | (int'($urandom_range(0, 31)) & ~((2 << cls) - 1) & 31)) : 0;
    x = 4'(px); y = 4'(py); big = pbig[0]; something_wrong = pwrong[0];
    is_hit = hit[0]; is_near_miss = near[0]; is_miss = miss[0]; biggest_ship = 5'(bs);
    pulses = 0;
    score_L = 1'b0;
    repeat (phold) begin @(posedge clock); #1; if (shot_done) pulses++; end
    score_L = 1'b1;
    repeat (8) begin @(posedge clock); #1; if (shot_done) pulses++; end
    if (go_m != 0 || pwrong != 0 || px < 1 || px > 10 || py < 1 || py > 10 || (pbig != 0 && bl_m == 0)) begin
      rej_m = 1; rpt_m = 0;
    end else begin
      rej_m = 0; rpt_m = 0;
      hl_m = hit; nl_m = near; ml_m = miss; sh_m = bs;
      if (pbig != 0) bl_m--;
      sl_m--;
      if (fired_m[px][py]) rpt_m = 1;
      else begin
        fired_m[px][py] = 1'b1;
        if (hit != 0) begin
          if (hits_m < 19) hits_m++;
          if (cnt_m[cls] < need[cls]) cnt_m[cls]++;
        end
      end
    end
    if (hits_m == 19) go_m = 1;
`ifdef SHOT_LIMIT_EN
    if (sl_m == 0) go_m = 1;
`endif
    check($sformatf("shot(%0d,%0d) shot_done pulses", px, py), pulses, 1);
    check_outputs($sformatf("shot(%0d,%0d)", px, py));
  endtask

  initial begin
    int px, py, got_pulse;
    model_reset();
    #12;
    check_outputs("in reset");
    check("in reset shot_done", shot_done, 0);
    #11 reset_L = 1'b1;
    repeat (3) @(posedge clock);
    #1 check_outputs("after reset");

    press(7, 6, 0, 0, 8);
    press(7, 6, 0, 0, 8);
    press(8, 6, 0, 0, 7);
    press(9, 1, 0, 0, 9);
    press(10, 1, 0, 0, 6);

    press(2, 2, 1, 0, 8);
    press(2, 3, 1, 0, 8);
    press(2, 4, 1, 0, 8);

    press(6, 9, 0, 1, 50);

    for (int n = 0; n < 40; n++) begin
      px = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(11, 15)))
                                       : int'($urandom_range(1, 10));
      py = int'($urandom_range(1, 10));
      press(px, py, ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
            int'($urandom_range(6, 12)));
    end

    for (int i = 0; i < 19; i++) press(cell_x[i], cell_y[i], 0, 0, int'($urandom_range(6, 10)));
    press(1, 10, 0, 0, 8);

    x = 4'd3; y = 4'd3; something_wrong = 1'b0; big = 1'b0;
    score_L = 1'b0;
    got_pulse = 0;
    for (int c = 0; c < 20 && got_pulse == 0; c++) begin
      @(posedge clock); #1;
      if (shot_done) got_pulse = 1;
    end
    check("mid-release shot_done seen", got_pulse, 1);
    repeat (2) @(posedge clock);
    #3 reset_L = 1'b0;
    score_L = 1'b1;
    model_reset();
    #2 check_outputs("reset mid-release");
    #14 reset_L = 1'b1;
    repeat (4) @(posedge clock);
    #1 check_outputs("after mid-release reset");
    press(7, 6, 0, 0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_score_keeper.md
Name: shot_score_keeper

Overview:
- Sequential game-state stage downstream of the combinational shot checker (square check, near-miss check, validity check).
- Turns a raw "score this" key press into one scored shot.
- Keeps the fired-cell bitmap, the hit count, per-class ship hit counts and sunk flags, big bombs remaining, and game-over state.
- Feeds hit/near-miss/miss LED latches, the hit-count digits and the big-bombs-left value to the display stage.

Parameters:
- BIG_BOMBS, 2: big bombs available at reset (fits 2 bits).
- TOTAL_CELLS, 19: ship cells on the board; game over when hit count reaches it.
- MAX_SHOTS, 30: shot budget, used only with SHOT_LIMIT_EN.

Ports:
- clock  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- score_L  in  1  raw KEY[0], active-low, asynchronous to clock
- x  in  4  shot column, 1..10
- y  in  4  shot row, 1..10
- big  in  1  big bomb requested
- something_wrong  in  1  validity-checker result for current x/y/big
- is_hit, is_near_miss, is_miss  in  1 each  checker result for current x/y
- biggest_ship  in  5  one-hot ship class hit (bit0 patrol … bit4 carrier), 0 on miss
- shot_done  out  1  one-cycle pulse when a shot is scored
- reject  out  1  sticky until next press: last press refused
- repeat_shot  out  1  sticky until next press: last cell already fired
- hit_led, near_led, miss_led  out  1 each  latched result of last scored shot
- ship_hit  out  5  latched biggest_ship of last scored shot
- ship_sunk  out  5  per-class sunk flags
- num_hits  out  5  distinct ship cells hit, 0..TOTAL_CELLS
- hits_ones, hits_tens  out  4 each  BCD of num_hits
- big_left  out  2  big bombs remaining
- game_over  out  1  all ships sunk (or shots exhausted)

Behaviour:
- Reset (async on reset_L low) clears:
  - fired bitmap and all counters;
  - all outputs to 0, except big_left = BIG_BOMBS;
  - synchronizer flops to 1 (key released).
  - Reset mid-shot abandons the shot with no partial update.
- Input conditioning:
  - score_L passes through a 2-flop synchronizer, then a falling-edge detector (press = synced 1→0).
  - Press is seen 3 clocks after the pin falls.
- FSM:
  - IDLE: on press, register x, y, big, something_wrong and all checker outputs; go to SCORE.
  - SCORE (one cycle): apply the decision below; assert shot_done; go to RELEASE.
  - RELEASE: wait until synced score_L = 1, then go to IDLE. Presses during SCORE or RELEASE are ignored.
- SCORE decision, in priority order:
  1. game_over = 1 → reject = 1, no state change.
  2. something_wrong, or x/y outside 1..10 → reject = 1.
  3. big = 1 and big_left = 0 → reject = 1.
  4. Cell already in fired bitmap → repeat_shot = 1. LEDs and ship_hit update; counters do not change. big_left still decrements if big.
  5. Otherwise:
     - set bitmap bit [(y-1)*10 + (x-1)];
     - latch LEDs and ship_hit;
     - if is_hit: num_hits +1, class counter of the set biggest_ship bit +1;
     - if big: big_left −1.
- reject and repeat_shot clear on the next accepted press (IDLE→SCORE).
- Sunk flags:
  - ship_sunk[k] = 1 when class counter k equals SHIP_CELLS[k] (4,3,3,4,5).
  - Class counters and num_hits saturate; they never exceed their size.
- game_over:
  - Registered; sets in the cycle after num_hits reaches TOTAL_CELLS.
  - Stays set until reset.
- BCD:
  - hits_tens/hits_ones are combinational from num_hits (0..19 → tens 0/1).
- Latency:
  - Outputs update on the clock edge ending SCORE.
  - From a detected press: 2 clocks to updated outputs.
- Multiple biggest_ship bits set: the lowest set bit is used.

Optional Feature:
- SHOT_LIMIT_EN defined:
  - adds a shots_left output (5 bits), reset to MAX_SHOTS;
  - shots_left decrements on every non-rejected shot, including repeats;
  - game_over also sets when shots_left reaches 0.
- Not defined: no shot counter; game_over only on all ships sunk.

Decomposition:
- Package battleship_pkg:
  - ship-class enum / one-hot indices;
  - SHIP_CELLS constant array;
  - BOARD_DIM = 10;
  - FSM state typedef (IDLE, SCORE, RELEASE).
- One sub-module key_press_sync: 2-flop synchronizer plus falling-edge pulse, with clock/reset_L.

Test Plan:
- Reset, then press at (7,6), is_hit, ship bit0 → shot_done one pulse; num_hits 1; hit_led 1; ship_sunk 0.
- Press again at (7,6) → repeat_shot 1; num_hits stays 1; reject 0.
- Hit (7,6),(8,6),(9,1),(10,1) → ship_sunk[0] 1 after the 4th hit; hits_ones 4.
- Big press three times, valid misses → big_left 2→1→0; 3rd press reject 1, big_left 0.
- something_wrong = 1 on press → reject 1, no bitmap/counter change. Hold key 50 clocks → exactly one shot_done.
- Hit all 19 ship cells → game_over 1, hits_tens 1, hits_ones 9. Further press → reject 1. Assert reset_L mid-RELEASE → all cleared, big_left 2.
